binary_bbox_stat: RTL and testbench

//  Consumer end of the binary ISP stream (post_frame_vsync/href/clken/post_img_Bit).

---
 rtl/isp_pkg.sv | 28 ++
 rtl/frame_pos_counter.sv | 79 +++++++
 rtl/binary_bbox_stat.sv | 114 +++++++++++
 tb/tb_binary_bbox_stat.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared widths, default frame geometry, FSM encodings and the bounding-box
// record used by the binary ISP statistics blocks.
package isp_pkg;

  localparam int XW           = 11;  // x coordinate width
  localparam int YW           = 10;  // y coordinate width
  localparam int AW           = 20;  // saturating area counter width
  localparam int DEF_IMG_W    = 640;
  localparam int DEF_IMG_H    = 480;
  localparam int DEF_MIN_AREA = 64;

  // Frame FSM encodings, exported on dbg_state
  localparam logic [1:0] ST_WAIT_SOF = 2'd0;
  localparam logic [1:0] ST_ACCUM    = 2'd1;
  localparam logic [1:0] ST_LATCH    = 2'd2;

  typedef struct packed {
    logic [XW-1:0] x_min;
    logic [XW-1:0] x_max;
    logic [YW-1:0] y_min;
    logic [YW-1:0] y_max;
    logic [AW-1:0] area;
  } bbox_t;

  // Accumulator start value: min at all-ones, max and area at zero
  localparam bbox_t BBOX_INIT = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0, area: '0};

endpackage

// File: rtl/frame_pos_counter.sv
// Registers the incoming binary stream once, detects vsync rise / href fall on
// the registered copies, tracks pixel coordinates and flags foreground pixels
// that fall inside the active window with accumulation enabled.
module frame_pos_counter
  import isp_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          href,
  input  logic          clken,
  input  logic          bit_in,
  input  logic          en,
  output logic          vs_rise,
  output logic          pix_fg,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y
);

  localparam logic [XW-1:0] X_LIM = XW'(IMG_W);
  localparam logic [YW-1:0] Y_LIM = YW'(IMG_H);

  logic vs_r, vs_d, hr_r, hr_d, ck_r, bit_r, en_r;
  logic hr_fall, pix_qual, accept;

  // Single register stage on every stream input, plus one more on the syncs for edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_r  <= 1'b0;
      vs_d  <= 1'b0;
      hr_r  <= 1'b0;
      hr_d  <= 1'b0;
      ck_r  <= 1'b0;
      bit_r <= 1'b0;
      en_r  <= 1'b0;
    end else begin
      vs_r  <= vsync;
      vs_d  <= vs_r;
      hr_r  <= href;
      hr_d  <= hr_r;
      ck_r  <= clken;
      bit_r <= bit_in;
      en_r  <= en;
    end
  end

  assign vs_rise  = vs_r & ~vs_d;
  assign hr_fall  = ~hr_r & hr_d;
  // A qualified pixel strobe inside a line; pixels during vsync never count
  assign pix_qual = hr_r & ck_r & ~vs_r;
  assign accept   = pix_qual & (x < X_LIM) & (y < Y_LIM);
  assign pix_fg   = accept & en_r & bit_r;

  // Column counter: restarts every line, saturates rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
    end else if (vs_rise || hr_fall) begin
      x <= '0;
    end else if (pix_qual && (x != '1)) begin
      x <= x + 1'b1;
    end
  end

  // Row counter: advances at the end of each line, restarts at frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (vs_rise) begin
      y <= '0;
    end else if (hr_fall && (y != '1)) begin
      y <= y + 1'b1;
    end
  end

endmodule

// File: rtl/binary_bbox_stat.sv
// Per-frame bounding box and area of foreground pixels in a binary stream.
// Results of a frame are published at the following vsync rise with a
// one-cycle o_valid strobe; the partial frame seen after reset is discarded.
module binary_bbox_stat
  import isp_pkg::*;
#(
  parameter int IMG_W    = DEF_IMG_W,
  parameter int IMG_H    = DEF_IMG_H,
  parameter int MIN_AREA = DEF_MIN_AREA
) (
  input  logic          pixelclk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          post_frame_vsync,
  input  logic          post_frame_href,
  input  logic          post_frame_clken,
  input  logic          post_img_Bit,
  output logic [XW-1:0] o_x_min,
  output logic [XW-1:0] o_x_max,
  output logic [YW-1:0] o_y_min,
  output logic [YW-1:0] o_y_max,
  output logic [AW-1:0] o_area,
  output logic          o_found,
  output logic          o_valid,
  output logic [1:0]    dbg_state
);

  localparam logic [AW-1:0] MIN_A = AW'(MIN_AREA);

  logic          vs_rise, pix_fg;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    state;
  bbox_t         acc;
  logic          publish;

  frame_pos_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
    .clk    (pixelclk),
    .rst_n  (rst_n),
    .vsync  (post_frame_vsync),
    .href   (post_frame_href),
    .clken  (post_frame_clken),
    .bit_in (post_img_Bit),
    .en     (en),
    .vs_rise(vs_rise),
    .pix_fg (pix_fg),
    .x      (x),
    .y      (y)
  );

  // Only a frame boundary seen while accumulating closes a complete frame
  assign publish   = vs_rise && (state == ST_ACCUM);
  assign dbg_state = state;

  // Frame FSM: skip the partial frame after reset, then alternate ACCUM/LATCH
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT_SOF;
    end else begin
      case (state)
        ST_WAIT_SOF: if (vs_rise) state <= ST_ACCUM;
        ST_ACCUM:    if (vs_rise) state <= ST_LATCH;
        ST_LATCH:    state <= ST_ACCUM;
        default:     state <= ST_WAIT_SOF;
      endcase
    end
  end

  // Min/max/area accumulation; every frame boundary restarts from the init value
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= BBOX_INIT;
    end else if (vs_rise) begin
      acc <= BBOX_INIT;
    end else if (pix_fg) begin
      if (x < acc.x_min) acc.x_min <= x;
      if (x > acc.x_max) acc.x_max <= x;
      if (y < acc.y_min) acc.y_min <= y;
      if (y > acc.y_max) acc.y_max <= y;
      if (acc.area != '1) acc.area <= acc.area + 1'b1;
    end
  end

  // Result latch: loaded on entry to LATCH so o_valid is high for the LATCH cycle
  always_ff @(posedge pixelclk or negedge rst_n) begin
    if (!rst_n) begin
      o_x_min <= '0;
      o_x_max <= '0;
      o_y_min <= '0;
      o_y_max <= '0;
      o_area  <= '0;
      o_found <= 1'b0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= publish;
      if (publish) begin
        if (acc.area == '0) begin
          o_x_min <= '0;
          o_x_max <= '0;
          o_y_min <= '0;
          o_y_max <= '0;
        end else begin
          o_x_min <= acc.x_min;
          o_x_max <= acc.x_max;
          o_y_min <= acc.y_min;
          o_y_max <= acc.y_max;
        end
        o_area  <= acc.area;
        o_found <= (acc.area >= MIN_A);
      end
    end
  end

endmodule

// File: tb/tb_binary_bbox_stat.sv
// Bench for binary_bbox_stat on a reduced 40x30 window. Frames are described
// as pixel/enable arrays; expected results come from constants or a direct
// scan of those arrays.
module tb_binary_bbox_stat;
  import isp_pkg::*;

  localparam int W    = 40;
  localparam int H    = 30;
  localparam int MINA = 64;
  localparam int ML   = H + 2;
  localparam int MC   = W + 20;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, vsync = 1'b0, href = 1'b0, clken = 1'b0, bitv = 1'b0;
  logic [XW-1:0] o_x_min, o_x_max;
  logic [YW-1:0] o_y_min, o_y_max;
  logic [AW-1:0] o_area;
  logic          o_found, o_valid;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  binary_bbox_stat #(.IMG_W(W), .IMG_H(H), .MIN_AREA(MINA)) dut (
    .pixelclk        (clk),
    .rst_n           (rst_n),
    .en              (en),
    .post_frame_vsync(vsync),
    .post_frame_href (href),
    .post_frame_clken(clken),
    .post_img_Bit    (bitv),
    .o_x_min         (o_x_min),
    .o_x_max         (o_x_max),
    .o_y_min         (o_y_min),
    .o_y_max         (o_y_max),
    .o_area          (o_area),
    .o_found         (o_found),
    .o_valid         (o_valid),
    .dbg_state       (dbg_state)
  );

  int checks = 0;
  int failures = 0;

  logic fb [0:ML-1][0:MC-1];
  logic fe [0:ML-1][0:MC-1];

  initial begin
    #3000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- frame description helpers ----------------
  task automatic clear_frame(input logic ev);
    for (int yy = 0; yy < ML; yy++)
      for (int xx = 0; xx < MC; xx++) begin
        fb[yy][xx] = 1'b0;
        fe[yy][xx] = ev;
      end
  endtask

  task automatic fill_rect(input int x0, input int x1, input int y0, input int y1);
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++) fb[yy][xx] = 1'b1;
  endtask

  // Reference: scan the visible window of the described frame
  task automatic model(input int nl, input int nc, output bbox_t e, output logic f);
    int xmn, xmx, ymn, ymx, cnt;
    xmn = 1 << 30; xmx = -1; ymn = 1 << 30; ymx = -1; cnt = 0;
    for (int yy = 0; yy < nl; yy++)
      for (int xx = 0; xx < nc; xx++)
        if (yy < H && xx < W && fb[yy][xx] && fe[yy][xx]) begin
          cnt++;
          if (xx < xmn) xmn = xx;
          if (xx > xmx) xmx = xx;
          if (yy < ymn) ymn = yy;
          if (yy > ymx) ymx = yy;
        end
    e = '0;
    if (cnt > 0) begin
      e.x_min = XW'(xmn); e.x_max = XW'(xmx);
      e.y_min = YW'(ymn); e.y_max = YW'(ymx);
    end
    e.area = AW'(cnt);
    f = (cnt >= MINA);
  endtask

  // ---------------- drivers (inputs change right after negedge) ----------------
  task automatic send_lines(input int nl, input int nc);
    for (int yy = 0; yy < nl; yy++) begin
      int c;
      c = 0;
      while (c < nc) begin
        href = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          clken = 1'b0; bitv = 1'($urandom); en = 1'($urandom);
        end else begin
          clken = 1'b1; bitv = fb[yy][c]; en = fe[yy][c]; c++;
        end
        @(negedge clk);
      end
      href = 1'b0; clken = 1'b0; bitv = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  // Frame boundary: vsync pulse, collect any o_valid strobes within 8 cycles
  task automatic vsync_capture(output int npulse, output int lat, output bbox_t got, output logic gf);
    npulse = 0; lat = -1; got = '0; gf = 1'b0;
    vsync = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (o_valid) begin
        npulse++;
        if (lat < 0) lat = i;
        got = '{o_x_min, o_x_max, o_y_min, o_y_max, o_area};
        gf  = o_found;
      end
      if (i == 4) vsync = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic bbox_t mk(input int a, input int b, input int c, input int d, input int ar);
    mk = '{XW'(a), XW'(b), YW'(c), YW'(d), AW'(ar)};
  endfunction

  function automatic bbox_t outs();
    outs = '{o_x_min, o_x_max, o_y_min, o_y_max, o_area};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== '0 || o_found !== 1'b0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h found=%b valid=%b exp=0", outs(), o_found, o_valid);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", o_valid);
    end
  endtask

  task automatic test_first_frame();
    int np, lat; bbox_t g; logic gf;
    clear_frame(1'b1);
    fb[5][10] = 1'b1;
    send_lines(H, W);
    vsync_capture(np, lat, g, gf);
    checks++;
    if (np !== 0) begin
      failures++;
      $display("FAIL first_frame_no_valid pulses=%0d exp=0", np);
    end
    send_lines(H, W);
    vsync_capture(np, lat, g, gf);
    checks++;
    if (np !== 1 || lat !== 2) begin
      failures++;
      $display("FAIL single_px_strobe pulses=%0d lat=%0d exp pulses=1 lat=2", np, lat);
    end
    checks++;
    if (g !== mk(10, 10, 5, 5, 1) || gf !== 1'b0) begin
      failures++;
      $display("FAIL single_px got=%0d/%0d/%0d/%0d a=%0d f=%b exp=10/10/5/5 a=1 f=0",
               g.x_min, g.x_max, g.y_min, g.y_max, g.area, gf);
    end
  endtask

  task automatic test_rect();
    int np, lat; bbox_t g; logic gf;
    clear_frame(1'b1);
    fill_rect(8, 23, 2, 9);
    send_lines(H, W);
    vsync_capture(np, lat, g, gf);
    checks++;
    if (np !== 1 || g !== mk(8, 23, 2, 9, 128) || gf !== 1'b1) begin
      failures++;
      $display("FAIL rect n=%0d got=%0d/%0d/%0d/%0d a=%0d f=%b exp=8/23/2/9 a=128 f=1",
               np, g.x_min, g.x_max, g.y_min, g.y_max, g.area, gf);
    end
  endtask

  task automatic test_threshold();
    int np, lat; bbox_t g; logic gf;
    clear_frame(1'b1);
    fill_rect(0, 7, 20, 27);            // exactly 64 pixels
    send_lines(H, W);
    vsync_capture(np, lat, g, gf);
    checks++;
    if (np !== 1 || g !== mk(0, 7, 20, 27, 64) || gf !== 1'b1) begin
      failures++;
      $display("FAIL area_eq_min n=%0d area=%0d f=%b exp area=64 f=1", np, g.area, gf);
    end
    fb[27][7] = 1'b0;                   // 63 pixels, bbox unchanged
    send_lines(H, W);
    vsync_capture(np, lat, g, gf);
    checks++;
    if (np !== 1 || g !== mk(0, 7, 20, 27, 63) || gf !== 1'b0) begin
      failures++;
      $display("FAIL area_below_min n=%0d area=%0d f=%b exp area=63 f=0", np, g.area, gf);
    end
  endtask

  task automatic test_empty();
    int np, lat; bbox_t g; logic gf;
    clear_frame(1'b1);
    send_lines(H, W);
    vsync_capture(np, lat, g, gf);
    checks++;
    if (np !== 1 || g !== '0 || gf !== 1'b0) begin
      failures++;
      $display("FAIL empty n=%0d got=%h f=%b exp n=1 all 0", np, g, gf);
    end
  endtask

  task automatic test_en_rows();
    int np, lat; bbox_t g; logic gf;
    clear_frame(1'b1);
    fill_rect(0, W - 1, 0, H - 1);
    for (int yy = 0; yy < H / 2; yy++)
      for (int xx = 0; xx < MC; xx++) fe[yy][xx] = 1'b0;
    send_lines(H, W);
    vsync_capture(np, lat, g, gf);
    checks++;
    if (np !== 1 || g !== mk(0, W - 1, H / 2, H - 1, W * H / 2) || gf !== 1'b1) begin
      failures++;
      $display("FAIL en_rows got=%0d/%0d/%0d/%0d a=%0d f=%b exp=0/39/15/29 a=600 f=1",
               g.x_min, g.x_max, g.y_min, g.y_max, g.area, gf);
    end
  endtask

  task automatic test_overrun();
    int np, lat; bbox_t g; logic gf;
    clear_frame(1'b1);
    fill_rect(0, MC - 1, 0, ML - 1);
    send_lines(ML, MC);                 // 20 extra columns, 2 extra lines
    vsync_capture(np, lat, g, gf);
    checks++;
    if (np !== 1 || g !== mk(0, W - 1, 0, H - 1, W * H) || gf !== 1'b1) begin
      failures++;
      $display("FAIL overrun got=%0d/%0d/%0d/%0d a=%0d exp=0/39/0/29 a=1200",
               g.x_min, g.x_max, g.y_min, g.y_max, g.area);
    end
  endtask

  task automatic test_random();
    int np, lat, nl, nc, p; bbox_t g, e; logic gf, ef;
    for (int k = 0; k < 6; k++) begin
      p = $urandom_range(0, 100);
      if (k == 0) p = 2;
      nl = $urandom_range(H - 3, H + 2);
      nc = $urandom_range(W - 5, W + 5);
      for (int yy = 0; yy < ML; yy++)
        for (int xx = 0; xx < MC; xx++) begin
          fb[yy][xx] = ($urandom_range(0, 99) < p);
          fe[yy][xx] = ($urandom_range(0, 9) != 0);
        end
      model(nl, nc, e, ef);
      send_lines(nl, nc);
      vsync_capture(np, lat, g, gf);
      checks++;
      if (np !== 1 || lat !== 2 || g !== e || gf !== ef) begin
        failures++;
        $display("FAIL random%0d n=%0d lat=%0d got=%0d/%0d/%0d/%0d a=%0d f=%b exp=%0d/%0d/%0d/%0d a=%0d f=%b",
                 k, np, lat, g.x_min, g.x_max, g.y_min, g.y_max, g.area, gf,
                 e.x_min, e.x_max, e.y_min, e.y_max, e.area, ef);
      end
      // Outputs must hold through the following frame until its boundary
      send_lines(3, W);
      checks++;
      if (outs() !== e || o_found !== ef) begin
        failures++;
        $display("FAIL hold%0d got=%h f=%b exp=%h f=%b", k, outs(), o_found, e, ef);
      end
      vsync_capture(np, lat, g, gf);   // flush the short frame
    end
  endtask

  task automatic test_reset_mid();
    int np, lat; bbox_t g, e; logic gf, ef;
    clear_frame(1'b1);
    fill_rect(3, 30, 4, 12);
    send_lines(6, W);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (outs() !== '0 || o_found !== 1'b0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h f=%b v=%b exp=0", outs(), o_found, o_valid);
    end
    rst_n = 1'b1;
    send_lines(H, W);
    vsync_capture(np, lat, g, gf);
    checks++;
    if (np !== 0) begin
      failures++;
      $display("FAIL mid_reset_no_valid pulses=%0d exp=0", np);
    end
    model(H, W, e, ef);
    send_lines(H, W);
    vsync_capture(np, lat, g, gf);
    checks++;
    if (np !== 1 || g !== e || gf !== ef) begin
      failures++;
      $display("FAIL after_reset n=%0d got=%h f=%b exp=%h f=%b", np, g, gf, e, ef);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_first_frame();
    test_rect();
    test_threshold();
    test_empty();
    test_en_rows();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
